// File: rtl/alu_pkg.sv
// Shared ALU definitions: control-code constants, code width and the
// response-slot state encoding used by the ALU share arbiter.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0100;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant. The pointer remembers the last winner so that
// under continuous contention the grants alternate. Reset points at
// requester 1, which makes requester 0 win the first contended grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic       gnt_vld,
  output logic       gnt_id
);

  logic last;

  // Pick the lone requester, or the one that did not win last time.
  always_comb begin
    gnt_id  = (req == 2'b11) ? ~last : req[1];
    gnt_vld = en & (|req);
  end

  // Advance the pointer only when a grant is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last <= 1'b1;
    else if (gnt_vld) last <= gnt_id;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters. One request
// is granted per cycle (round-robin), driven onto the ALU, and its result is
// captured into a single response slot tagged with the requester id.
// Optional build macro ALU_ARB_OPCHECK_EN: illegal opcodes are still accepted
// but executed as ADD, reported with rsp_err=1 and rsp_data=0.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = ALU_OP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [OP_W-1:0]  alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err
);

  arb_state_t       state;
  logic             can_accept;
  logic             gnt_vld;
  logic             gnt_id;
  logic             op_bad;
  logic [OP_W-1:0]  sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // The slot can take a new result when empty or when it is drained this cycle.
  assign can_accept = (state == IDLE) || rsp_ready;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (can_accept),
    .req     ({req1_valid, req0_valid}),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  assign req0_ready = gnt_vld & ~gnt_id;
  assign req1_ready = gnt_vld &  gnt_id;

  // Route the granted requester's operation.
  always_comb begin
    sel_op = gnt_id ? req1_op : req0_op;
    sel_a  = gnt_id ? req1_a  : req0_a;
    sel_b  = gnt_id ? req1_b  : req0_b;
  end

`ifdef ALU_ARB_OPCHECK_EN
  assign op_bad = gnt_vld && (sel_op > OP_W'(ALU_XOR));
`else
  assign op_bad = 1'b0;
`endif

  // Drive the shared ALU only while a grant is live; park it at zero otherwise.
  always_comb begin
    alu_ctrl = '0;
    alu_a    = '0;
    alu_b    = '0;
    if (gnt_vld) begin
      alu_ctrl = op_bad ? '0 : sel_op;
      alu_a    = sel_a;
      alu_b    = sel_b;
    end
  end

  // Response slot FSM: capture on accept, empty on drain, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
    end else if (gnt_vld) begin
      state     <= FULL;
      rsp_valid <= 1'b1;
      rsp_id    <= gnt_id;
      rsp_data  <= op_bad ? '0 : alu_result;
      rsp_zero  <= alu_zero;
    end else if (state == FULL && rsp_ready) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  // Error flag travels with the captured result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rsp_err <= 1'b0;
    else if (gnt_vld) rsp_err <= op_bad;
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single ALU between two requesters: req0 is the core datapath and req1 is a secondary unit such as the address generator or CSR helper.
- Each requester presents an ALU control code and two operands with a valid/ready handshake.
- The arbiter selects one request per cycle using round-robin, drives the shared ALU inputs, and registers the result into a response slot tagged with the requester ID.
- Sits between the requesters and the ALU instance; ALU control codes use the existing 4-bit encoding.

Parameters:
- WIDTH, 32, operand/result width in bits.
- OP_W, 4, ALU control code width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  OP_W  ALU control code (ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100).
- req0_a, req0_b  input  WIDTH  operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1.
- alu_ctrl  output  OP_W  to shared ALU control input.
- alu_a, alu_b  output  WIDTH  to shared ALU operands.
- alu_result  input  WIDTH  shared ALU result, combinational.
- alu_zero  input  1  shared ALU zero flag.
- rsp_valid  output  1  response slot holds a result.
- rsp_ready  input  1  consumer takes the response.
- rsp_id  output  1  requester that owns the response.
- rsp_data  output  WIDTH  registered ALU result.
- rsp_zero  output  1  registered zero flag.
- rsp_err  output  1  illegal opcode flag; only driven when the optional feature is compiled in.

Behaviour:
- Reset (async on rst_n low):
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, rsp_err=0.
  - Round-robin pointer last_grant=1, so req0 wins first.
  - State=IDLE.
- Accept condition: can_accept = (state==IDLE) or (state==FULL and rsp_ready).
- Grant (combinational):
  - Only one requester valid: that requester.
  - Both valid: the one not equal to last_grant.
  - Grant only when can_accept.
- reqN_ready = can_accept and grant==N. Ready never asserts without the matching valid.
- ALU drive:
  - On a grant: alu_ctrl/alu_a/alu_b = granted requester's op/a/b in the same cycle.
  - No grant: alu_ctrl=4'b0000, alu_a=0, alu_b=0.
- On the accept edge:
  - rsp_data<=alu_result, rsp_zero<=alu_zero, rsp_id<=grant, rsp_valid<=1.
  - last_grant<=grant.
  - state<=FULL.
- Latency: accepted in cycle N gives rsp_valid in cycle N+1.
- Throughput: 1 op/cycle while rsp_ready stays high, with back-to-back accepts in FULL.
- FSM:
  - IDLE to FULL on accept.
  - FULL with rsp_ready and no new accept: to IDLE, rsp_valid<=0.
  - FULL with rsp_ready and a new accept: stays FULL, slot overwritten with the new result.
  - FULL without rsp_ready: hold; all rsp_* outputs stable; both ready outputs 0.
- Fairness: with both requesters valid continuously and rsp_ready=1, grants strictly alternate 0,1,0,1…
- A requester deasserting valid before ready is permitted; nothing is captured for it.
- Reset mid-operation: a pending response is discarded; no partial state survives.
- Arithmetic is performed only in the external ALU; this block performs no width conversion.

Optional Feature:
- Macro: ALU_ARB_OPCHECK_EN.
- Defined:
  - A granted op outside {0000..0100} is still accepted (ready asserted), but the ALU is driven with alu_ctrl=0000.
  - rsp_err<=1 and rsp_data<=0 for that response; rsp_err<=0 for legal ops.
- Undefined:
  - op is passed through unchanged.
  - rsp_err is tied to 0.

Decomposition:
- Shared package, alu_pkg:
  - ALU control code constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR.
  - ALU_OP_W.
  - State enum {IDLE, FULL}.
- One natural sub-module, rr_arb2: the 2-way round-robin grant with pointer update.
- The response slot and FSM stay in the top module.

Test Plan:
- Reset check: rst_n low mid-FULL → all rsp_* go to 0 asynchronously; after release, req0/req1 both valid → req0 granted first.
- Single op: req0 ADD a=5, b=7, rsp_ready=1 → cycle+1 rsp_valid=1, rsp_id=0, rsp_data=12, rsp_zero=0.
- Contention: both valid every cycle (req0 SUB 9-9, req1 XOR 0xF0^0x0F) → grants alternate; req0 responses show data=0/zero=1, req1 responses show data=0xFF/zero=0.
- Backpressure: rsp_ready=0 for 3 cycles while both valid → rsp_* held stable, both ready=0; rsp_ready=1 → next op accepted in the same cycle.
- Valid withdrawn: req1_valid pulses for one cycle while the slot is FULL and stalled → no req1_ready, no req1 response.
- With ALU_ARB_OPCHECK_EN: req1_op=4'b1010 → ready=1, alu_ctrl=0000, rsp_err=1, rsp_data=0. Without the macro → rsp_err stays 0.
